// File: rtl/lsm_sequencer.sv
// lsm_sequencer: walks an LDM/STM register list one bit per cycle, handing each selected
// register number to the control unit and holding it until acknowledged.
module lsm_sequencer #(
    parameter int NREGS = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_lsm_start,
    input  logic                         i_ir_23,
    input  logic [NREGS-1:0]             i_ir_15_0,
    input  logic                         i_lsm_next,
    output logic                         o_lsm_busy,
    output logic                         o_lsm_valid,
    output logic [$clog2(NREGS)-1:0]     o_lsm_reg_addr,
    output logic                         o_lsm_last,
    output logic [$clog2(NREGS+1)-1:0]   o_lsm_num_regs,
    output logic                         o_lsm_empty,
    output logic                         o_lsm_done
);
    localparam int CW = $clog2(NREGS);
    localparam int NW = $clog2(NREGS + 1);
    localparam logic [CW-1:0] TOP = CW'(NREGS - 1);

    typedef enum logic [1:0] {IDLE, CHECK, XFER, FINISH} state_t;

    state_t          r_state, w_state_nx;
    logic [NREGS-1:0] r_ahr, w_ahr_nx;
    logic            r_u, w_u_nx;
    logic [CW-1:0]   r_cnt, w_cnt_nx;
    logic [CW-1:0]   r_addr, w_addr_nx;
    logic            r_valid, w_valid_nx;
    logic            r_last, w_last_nx;
    logic [NW-1:0]   r_num, w_num_nx;
    logic            r_empty, w_empty_nx;

    logic            w_bit, w_term, w_rest_zero;
    logic [NREGS-1:0] w_ahr_sh;
    logic [CW-1:0]   w_cnt_st;
    logic [NW-1:0]   w_pop;

    // The scan bit always sits at the edge of LSMAHR the shift moves away from.
    assign w_bit       = r_u ? r_ahr[NREGS-1] : r_ahr[0];
    assign w_term      = r_u ? (r_cnt == '0) : (r_cnt == TOP);
    assign w_rest_zero = r_u ? (r_ahr[NREGS-2:0] == '0) : (r_ahr[NREGS-1:1] == '0);
    assign w_ahr_sh    = r_u ? {r_ahr[NREGS-2:0], 1'b0} : {1'b0, r_ahr[NREGS-1:1]};
    assign w_cnt_st    = r_u ? r_cnt - CW'(1) : r_cnt + CW'(1);

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NREGS; i++)
            w_pop = w_pop + NW'(i_ir_15_0[i]);
    end

    always_comb begin
        w_state_nx = r_state;
        w_ahr_nx   = r_ahr;
        w_u_nx     = r_u;
        w_cnt_nx   = r_cnt;
        w_addr_nx  = r_addr;
        w_valid_nx = r_valid;
        w_last_nx  = r_last;
        w_num_nx   = r_num;
        w_empty_nx = r_empty;
        case (r_state)
            IDLE: if (i_lsm_start) begin
                w_ahr_nx   = i_ir_15_0;
                w_u_nx     = i_ir_23;
                w_cnt_nx   = i_ir_23 ? TOP : '0;
                w_num_nx   = w_pop;
                w_empty_nx = (i_ir_15_0 == '0);
                w_state_nx = CHECK;
            end
            CHECK: if (w_bit) begin
                w_addr_nx  = r_cnt;
                w_valid_nx = 1'b1;
                w_last_nx  = w_rest_zero;
                w_state_nx = XFER;
            end else if (w_term) begin
                w_state_nx = FINISH;
            end else begin
                w_ahr_nx = w_ahr_sh;
                w_cnt_nx = w_cnt_st;
            end
            XFER: if (i_lsm_next) begin
                w_valid_nx = 1'b0;
                w_last_nx  = 1'b0;
                w_state_nx = w_term ? FINISH : CHECK;
                w_ahr_nx   = w_term ? r_ahr : w_ahr_sh;
                w_cnt_nx   = w_term ? r_cnt : w_cnt_st;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_ahr   <= '0;
            r_u     <= 1'b0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_num   <= '0;
            r_empty <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_ahr   <= w_ahr_nx;
            r_u     <= w_u_nx;
            r_cnt   <= w_cnt_nx;
            r_addr  <= w_addr_nx;
            r_valid <= w_valid_nx;
            r_last  <= w_last_nx;
            r_num   <= w_num_nx;
            r_empty <= w_empty_nx;
        end
    end

    assign o_lsm_busy     = (r_state != IDLE);
    assign o_lsm_done     = (r_state == FINISH);
    assign o_lsm_valid    = r_valid;
    assign o_lsm_reg_addr = r_addr;
    assign o_lsm_last     = r_last;
    assign o_lsm_num_regs = r_num;
    assign o_lsm_empty    = r_empty;
endmodule

// File: doc/lsm_sequencer.md
Name: lsm_sequencer

Overview:
- Sequential scanner for ARM LDM/STM register lists.
- Captures the 16-bit register list and U bit when the control unit starts a multiple transfer.
- Walks the list one bit per cycle and presents each selected register number to the control unit, holding it until the control unit acknowledges that transfer.
- Reports total register count, last-transfer and completion, so the control unit can sequence the memory accesses and base writeback.

Parameters:
- NREGS, 16, number of register-list bits scanned (fixed at 16 for ARM; counter width is 4 bits).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  synchronous reset, active-low.
- LSM_START  input  1  pulse from control unit: begin scan of IR_15_0.
- IR_23  input  1  U bit, sampled with LSM_START. 1 = scan R15 down to R0; 0 = scan R0 up to R15.
- IR_15_0  input  16  register list, sampled with LSM_START.
- LSM_NEXT  input  1  control unit acknowledge: current register transfer complete.
- LSM_BUSY  output  1  high from the cycle after an accepted start through the FINISH cycle.
- LSM_VALID  output  1  register number on LSM_REG_ADDR is valid and awaiting LSM_NEXT.
- LSM_REG_ADDR  output  4  register number of the current transfer.
- LSM_LAST  output  1  qualified by LSM_VALID: no further set bits remain after this one.
- LSM_NUM_REGS  output  5  popcount of the captured list (0..16), stable while busy.
- LSM_EMPTY  output  1  captured list was all zeros.
- LSM_DONE  output  1  one-cycle pulse: scan complete.

Behaviour:
- Reset (RST_N=0 at an edge): state=IDLE.
  - All outputs 0; LSM_REG_ADDR=0; LSM_NUM_REGS=0.
  - Shift register (LSMAHR) and counter cleared.
  - Reset overrides everything, including mid-scan; no LSM_DONE is produced for an aborted scan.
- States: IDLE, CHECK, XFER, FINISH.
- IDLE:
  - LSM_START=1 at an edge: load LSMAHR<=IR_15_0, latch U<=IR_23, counter<=15 if U else 0.
  - Same edge: LSM_NUM_REGS<=popcount(IR_15_0), LSM_EMPTY<=(IR_15_0==0). Go to CHECK.
- CHECK: the scan bit is LSMAHR[15] if U, LSMAHR[0] if not.
  - Bit set: go to XFER. At that edge register LSM_REG_ADDR<=counter, LSM_VALID<=1, and LSM_LAST<=(all bits still to be scanned ==0).
  - Bit clear, counter terminal (0 if U, 15 if not U): go to FINISH.
  - Bit clear, not terminal: shift LSMAHR (left if U, right if not; zero fill), step counter (-1 if U, +1 if not), stay in CHECK.
- XFER:
  - Outputs held stable while LSM_NEXT=0; no timeout.
  - LSM_NEXT=1, counter terminal: go to FINISH.
  - LSM_NEXT=1, not terminal: shift and step, go to CHECK.
  - LSM_VALID and LSM_LAST drop at the acknowledging edge.
- FINISH: LSM_DONE=1 for exactly one cycle, then IDLE. LSM_BUSY falls entering IDLE.
- Latency:
  - Start edge to first CHECK: 1 cycle.
  - First register visible 2 cycles after start if its bit is the first scanned; otherwise +1 cycle per clear bit skipped.
  - Empty list: 16 CHECK cycles, then FINISH. LSM_DONE pulses 17 cycles after start, with LSM_VALID never asserted.
- Ignored inputs:
  - LSM_START is ignored outside IDLE.
  - LSM_NEXT is ignored outside XFER.
  - IR inputs are sampled only at an accepted start.
- Counter never wraps. The terminal check prevents stepping past 0 or 15.
- LSM_NUM_REGS and LSM_EMPTY hold until the next accepted start or reset.

Test Plan:
- Reset mid-scan:
  - Stimulus: start with list 16'hFFFF, U=1; drop RST_N during the third XFER.
  - Required: next cycle all outputs 0 and state IDLE; no LSM_DONE. A new start is then accepted normally.
- Upward scan:
  - Stimulus: IR_23=0, list 16'h0005, LSM_NEXT=1 tied high.
  - Required: LSM_NUM_REGS=2. VALID with ADDR=0 (LAST=0), then VALID with ADDR=2 (LAST=1). Remaining 13 positions skipped, then one LSM_DONE pulse.
- Downward scan with stalls:
  - Stimulus: IR_23=1, list 16'h8001, LSM_NEXT held low 3 cycles per transfer.
  - Required: ADDR=15 held 3 cycles, then ADDR=0 with LAST=1; then DONE.
- Empty list:
  - Stimulus: list 16'h0000 with U=1; repeat with U=0.
  - Required (each case): LSM_EMPTY=1, LSM_NUM_REGS=0, VALID never asserted, LSM_DONE exactly 17 cycles after the start edge.
- Full list and ignored start:
  - Stimulus: list 16'hFFFF, U=0, NEXT high; pulse LSM_START again mid-scan.
  - Required: addresses 0..15 in order, LAST only on 15, NUM_REGS=16; second start has no effect.
- Terminal-bit edge case:
  - Stimulus: list 16'h8000 with U=0.
  - Required: 15 skip cycles, then ADDR=15 with LAST=1; after NEXT, FINISH with no counter wrap.
